data_memory_lsu: RTL and testbench

Parametrised byte-addressable data memory with a valid/ready request port and a registered response, for the MEM stage of the pipelined RISC-V core. It supports RV32I load/store sizes (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane writes and sign/zero extension. It reports misaligned, out-of-range and illegal-size accesses as faults, and inserts a configurable number of wait states to model slower memory.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/data_memory_lsu_if.sv | 25 ++
 rtl/dmem_load_ext.sv | 30 +++
 rtl/data_memory_lsu.sv | 154 +++++++++++++++
 tb/tb_data_memory_lsu.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory load/store unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/data_memory_lsu_if.sv
// Request/response bundle between the MEM stage and the data memory.
// Latency: n/a (wires only).
// Backpressure: request side uses valid/ready; response side has none.
// Ports: req_* (request valid/ready, write, funct3, addr, wdata), rsp_* (valid, rdata, fault).
interface data_memory_lsu_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_fault_o;

  modport master (
    output req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_fault_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_fault_o
  );
endinterface

// File: rtl/dmem_load_ext.sv
// Selects the addressed byte/half of a memory word and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: word (raw memory word), funct3 (load type), off (addr[1:0]), data (extended result).
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[{off, 3'b000} +: 8];
    sel_half = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    data = {{16{sel_half[15]}}, sel_half};
      F3_W:    data = word;
      F3_BU:   data = {24'd0, sel_byte};
      F3_HU:   data = {16'd0, sel_half};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressable data memory for the MEM stage: RV32I load/store sizes, fault detection.
// Latency: response 1+WAIT_STATES cycles after accept; stores commit at the accept edge.
// Backpressure: req_ready_o low while waiting out wait states; responses cannot be stalled.
// Ports: clk_i, rst_i (async active-high), bus (data_memory_lsu_if.slave).
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic             clk_i,
  input logic             rst_i,
  data_memory_lsu_if.slave bus
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  dmem_state_e      state;
  logic [3:0]       wait_cnt;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             out_of_range;
  logic             misaligned;
  logic             illegal;
  logic             fault;
  logic             do_store;
  logic [IDX_W-1:0] idx;
  logic [3:0]       byte_en;
  logic [31:0]      store_lanes;

  // captured at accept, consumed when the response is presented
  logic [31:0]      rd_word;
  logic [2:0]       hold_f3;
  logic [1:0]       hold_off;
  logic             hold_fault;
  logic             hold_write;

  logic [31:0]      ext_data;
  logic [31:0]      cur_rdata;
  logic [31:0]      last_rdata;
  logic             last_fault;

  assign bus.req_ready_o = !rst_i && (state != WAIT);
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign idx             = bus.req_addr_i[IDX_W+1:2];
  assign out_of_range    = (bus.req_addr_i >> (IDX_W + 2)) != 32'd0;
  assign fault           = out_of_range || misaligned || illegal;
  assign do_store        = accept && bus.req_write_i && !fault;

  always_comb begin
    misaligned = 1'b0;
    if (bus.req_funct3_i == F3_H || bus.req_funct3_i == F3_HU) begin
      misaligned = bus.req_addr_i[0];
    end else if (bus.req_funct3_i == F3_W) begin
      misaligned = bus.req_addr_i[1:0] != 2'd0;
    end
    if (bus.req_write_i) begin
      illegal = !(bus.req_funct3_i == F3_B || bus.req_funct3_i == F3_H ||
                  bus.req_funct3_i == F3_W);
    end else begin
      illegal = (bus.req_funct3_i == 3'b011) || (bus.req_funct3_i == 3'b110) ||
                (bus.req_funct3_i == 3'b111);
    end
  end

  // Store data is replicated across lanes so each enabled lane just takes its own byte.
  always_comb begin
    byte_en     = 4'b0000;
    store_lanes = bus.req_wdata_i;
    case (bus.req_funct3_i)
      F3_B: begin
        byte_en     = 4'b0001 << bus.req_addr_i[1:0];
        store_lanes = {4{bus.req_wdata_i[7:0]}};
      end
      F3_H: begin
        byte_en     = bus.req_addr_i[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{bus.req_wdata_i[15:0]}};
      end
      F3_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // Array has no reset; stores survive a reset of the control path.
  always_ff @(posedge clk_i) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= store_lanes[8*i +: 8];
      end
    end
    if (accept) rd_word <= mem[idx];
  end

  dmem_load_ext u_load_ext (
    .word   (rd_word),
    .funct3 (hold_f3),
    .off    (hold_off),
    .data   (ext_data)
  );

  assign cur_rdata = (hold_fault || hold_write) ? 32'd0 : ext_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      hold_f3    <= 3'd0;
      hold_off   <= 2'd0;
      hold_fault <= 1'b0;
      hold_write <= 1'b0;
      last_rdata <= 32'd0;
      last_fault <= 1'b0;
    end else begin
      // Remember the presented response so outputs hold until the next one,
      // even after the holding registers are reloaded by a new accept.
      if (state == RESP) begin
        last_rdata <= cur_rdata;
        last_fault <= hold_fault;
      end
      if (accept) begin
        hold_f3    <= bus.req_funct3_i;
        hold_off   <= bus.req_addr_i[1:0];
        hold_fault <= fault;
        hold_write <= bus.req_write_i;
      end
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid_o = (state == RESP);
  assign bus.rsp_rdata_o = (state == RESP) ? cur_rdata  : last_rdata;
  assign bus.rsp_fault_o = (state == RESP) ? hold_fault : last_fault;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench: two instances (0 and 3 wait states) against a byte-level reference model.
// Latency: checks response arrives 1+WAIT_STATES cycles after accept.
// Backpressure: checks req_ready_o pattern under continuously asserted requests.
module tb_data_memory_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1;
  int          sel;
  logic        req_valid, req_write;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;
  logic        rdy, rsp_v, rsp_f;
  logic [31:0] rsp_d;

  int errors = 0;
  int checks = 0;

  // reference memory, one byte per entry, per instance
  logic [7:0] mb [0:1][0:4095];

  data_memory_lsu_if if0 ();
  data_memory_lsu_if if1 ();

  assign if0.req_valid_i  = req_valid && (sel == 0);
  assign if1.req_valid_i  = req_valid && (sel == 1);
  assign if0.req_write_i  = req_write;
  assign if1.req_write_i  = req_write;
  assign if0.req_funct3_i = req_f3;
  assign if1.req_funct3_i = req_f3;
  assign if0.req_addr_i   = req_addr;
  assign if1.req_addr_i   = req_addr;
  assign if0.req_wdata_i  = req_wdata;
  assign if1.req_wdata_i  = req_wdata;

  assign rdy   = (sel == 1) ? if1.req_ready_o : if0.req_ready_o;
  assign rsp_v = (sel == 1) ? if1.rsp_valid_o : if0.rsp_valid_o;
  assign rsp_f = (sel == 1) ? if1.rsp_fault_o : if0.rsp_fault_o;
  assign rsp_d = (sel == 1) ? if1.rsp_rdata_o : if0.rsp_rdata_o;

  data_memory_lsu #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk_i (clk), .rst_i (rst0), .bus (if0)
  );
  data_memory_lsu #(.DEPTH_WORDS(256), .WAIT_STATES(3)) dut1 (
    .clk_i (clk), .rst_i (rst1), .bus (if1)
  );

  function automatic int ws_of();
    return (sel == 1) ? 3 : 0;
  endfunction

  function automatic int depth_of();
    return (sel == 1) ? 256 : 1024;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: fault rules and byte-lane semantics computed directly on a byte array.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic f, output logic [31:0] r);
    int unsigned nb;
    longint      limit;
    limit = 4 * depth_of();
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    f = 1'b0;
    r = 32'd0;
    if (longint'(a) >= limit) f = 1'b1;
    if (w && f3 > 3'd2) f = 1'b1;
    if (!w && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) f = 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) f = 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) f = 1'b1;
    if (!f) begin
      if (w) begin
        for (int i = 0; i < int'(nb); i++) mb[sel][a + i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < int'(nb); i++) r = r | (32'(mb[sel][a + i]) << (8 * i));
        if ((f3 == 3'd0 || f3 == 3'd1) && r[8*nb-1]) r = r | (32'hFFFF_FFFF << (8 * nb));
      end
    end
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] got);
    logic        ef;
    logic [31:0] ed;
    int          n;
    int          lat;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_f3 = f3; req_addr = a; req_wdata = d;
    n = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", {31'd0, rdy}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    model(w, f3, a, d, ef, ed);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_v && lat < 40);
    chk("rsp_latency", lat, 32'(1 + ws_of()));
    chk("rsp_fault", {31'd0, rsp_f}, {31'd0, ef});
    chk("rsp_rdata", rsp_d, ed);
    got = rsp_d;
  endtask

  task automatic fill_and_random(input int n);
    logic [31:0] got, a;
    int          d4;
    d4 = 4 * depth_of();
    for (int i = 0; i < 16; i++) do_req(1'b1, 3'b010, 32'(4 * i), $urandom, got);
    do_req(1'b1, 3'b010, 32'(d4 - 8), $urandom, got);
    do_req(1'b1, 3'b010, 32'(d4 - 4), $urandom, got);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) a = 32'(d4 - 8 + int'($urandom_range(0, 15)));
      else                           a = 32'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, got);
    end
  endtask

  logic [31:0] got;
  logic        ef;
  logic [31:0] ed;
  logic [31:0] exp_d [3];
  logic        exp_f [3];

  task automatic set_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int slot);
    logic        f;
    logic [31:0] r;
    req_valid = 1'b1; req_write = w; req_f3 = f3; req_addr = a; req_wdata = d;
    model(w, f3, a, d, f, r);
    exp_f[slot] = f;
    exp_d[slot] = r;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; sel = 0;
    req_valid = 1'b0; req_write = 1'b0; req_f3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;

    // reset state
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_v}, 32'd0);
    chk("rst_rdata", rsp_d, 32'd0);
    chk("rst_fault", {31'd0, rsp_f}, 32'd0);
    #2 rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, rdy}, 32'd1);
    chk("post_rst_rsp_valid", {31'd0, rsp_v}, 32'd0);

    // SW then LW back-to-back, zero wait states
    req_valid = 1'b1; req_write = 1'b1; req_f3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 model(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, ef, ed);
    req_write = 1'b0;
    @(negedge clk);
    chk("sw_rsp_valid", {31'd0, rsp_v}, 32'd1);
    chk("sw_rsp_rdata", rsp_d, 32'd0);
    chk("sw_rsp_fault", {31'd0, rsp_f}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("lw_rsp_valid", {31'd0, rsp_v}, 32'd1);
    chk("lw_rsp_rdata", rsp_d, 32'hDEADBEEF);
    chk("lw_rsp_fault", {31'd0, rsp_f}, 32'd0);
    @(negedge clk);
    chk("idle_rsp_valid", {31'd0, rsp_v}, 32'd0);
    chk("hold_rdata", rsp_d, 32'hDEADBEEF);
    model(1'b0, 3'b010, 32'h10, 32'd0, ef, ed);

    // byte store and sign/zero-extended loads
    do_req(1'b1, 3'b000, 32'h11, 32'h0000_0080, got);
    do_req(1'b0, 3'b000, 32'h11, 32'd0, got);
    chk("lb_const", got, 32'hFFFF_FF80);
    do_req(1'b0, 3'b100, 32'h11, 32'd0, got);
    chk("lbu_const", got, 32'h0000_0080);
    do_req(1'b0, 3'b010, 32'h10, 32'd0, got);
    chk("lw_merged", got, 32'hDEAD_80EF);

    // faults
    do_req(1'b0, 3'b001, 32'h13, 32'd0, got);
    chk("lh_mis_fault", {31'd0, rsp_f}, 32'd1);
    chk("lh_mis_rdata", got, 32'd0);
    do_req(1'b1, 3'b010, 32'h1002, 32'h1111_1111, got);
    chk("sw_mis_fault", {31'd0, rsp_f}, 32'd1);
    do_req(1'b0, 3'b010, 32'h1000, 32'd0, got);
    chk("lw_oor_fault", {31'd0, rsp_f}, 32'd1);
    chk("lw_oor_rdata", got, 32'd0);
    do_req(1'b1, 3'b100, 32'h10, 32'h2222_2222, got);
    chk("st_ill_fault", {31'd0, rsp_f}, 32'd1);
    do_req(1'b0, 3'b010, 32'h10, 32'd0, got);
    chk("lw_after_faults", got, 32'hDEAD_80EF);

    fill_and_random(150);

    // three wait states, request held valid back-to-back
    sel = 1;
    @(negedge clk);
    chk("ws3_idle_ready", {31'd0, rdy}, 32'd1);
    set_req(1'b1, 3'b010, 32'h20, 32'h1234_5678, 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("ws3_ready", {31'd0, rdy}, (k % 4 == 0) ? 32'd1 : 32'd0);
      chk("ws3_rsp_valid", {31'd0, rsp_v}, (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k % 4 == 0) begin
        chk("ws3_rsp_rdata", rsp_d, exp_d[k/4-1]);
        chk("ws3_rsp_fault", {31'd0, rsp_f}, {31'd0, exp_f[k/4-1]});
        if (k == 4)      set_req(1'b0, 3'b001, 32'h22, 32'd0, 1);
        else if (k == 8) set_req(1'b1, 3'b000, 32'h21, 32'h0000_00AB, 2);
        else             req_valid = 1'b0;
      end
    end
    do_req(1'b0, 3'b010, 32'h20, 32'd0, got);
    chk("ws3_lw_const", got, 32'h1234_AB78);

    // asynchronous reset while a load is in its wait states
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_f3 = 3'b010; req_addr = 32'h20;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    #2 rst1 = 1'b1;
    #1 chk("mid_rst_ready", {31'd0, rdy}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_v}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("in_rst_rsp_valid", {31'd0, rsp_v}, 32'd0);
    end
    #2 rst1 = 1'b0;
    @(negedge clk);
    chk("after_rst_ready", {31'd0, rdy}, 32'd1);
    repeat (6) begin
      @(negedge clk);
      chk("dropped_rsp_valid", {31'd0, rsp_v}, 32'd0);
    end
    do_req(1'b0, 3'b010, 32'h20, 32'd0, got);
    chk("after_rst_lw", got, 32'h1234_AB78);

    fill_and_random(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
